// File: rtl/divide_by_n.sv
// Divide-by-N clock enable: a free-running phase counter and a registered square wave,
// low for floor(N/2) cycles and high for ceil(N/2) cycles of every N-cycle period.
module divide_by_n #(
   parameter int N = 60
) (
   input  logic clk,
   input  logic reset,
   output logic out
);

   if (N < 2) begin : g_bad_n
      $fatal(1, "divide_by_n: parameter N must be >= 2");
   end

   localparam int            CW   = (N > 2) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);
   localparam logic [CW-1:0] HALF = CW'(N / 2);

   logic [CW-1:0] count;
   logic [CW-1:0] count_nxt;
   logic          out_nxt;

   // out is registered from the next count, so both flops move on the same edge
   always_comb begin
      count_nxt = count + 1'b1;
      if (count == LAST) begin
         count_nxt = '0;
      end
      out_nxt = (count_nxt >= HALF);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
         out   <= 1'b0;
      end else begin
         count <= count_nxt;
         out   <= out_nxt;
      end
   end

endmodule

// File: tb/tb_divide_by_n.sv
// Directed bench for divide_by_n: four instances (N = 60, 5, 2, 7) share one clock
// and one reset; a vector table covers fixed edges, hand sequences cover the rest.
module tb_divide_by_n;

   logic clk;
   logic reset;
   logic out60, out5, out2, out7;

   int tests;
   int failed;
   int edge_cnt;

   logic [31:0] exp_q[$];

   typedef struct {
      int   edge_idx;
      logic exp60;
      logic exp5;
      logic exp2;
      logic exp7;
   } vec_t;

   vec_t vecs[15];

   divide_by_n #(.N(60)) dut60 (.clk(clk), .reset(reset), .out(out60));
   divide_by_n #(.N(5))  dut5  (.clk(clk), .reset(reset), .out(out5));
   divide_by_n #(.N(2))  dut2  (.clk(clk), .reset(reset), .out(out2));
   divide_by_n #(.N(7))  dut7  (.clk(clk), .reset(reset), .out(out7));

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_cnt);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      edge_cnt++;
   endtask

   // assert reset between edges, hold it, release on a falling edge
   task automatic do_reset();
      @(negedge clk);
      #2;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset    = 1'b1;
      edge_cnt = 0;
   endtask

   initial begin
      tests    = 0;
      failed   = 0;
      edge_cnt = 0;
      reset    = 1'b0;

      vecs[0]  = '{0,  1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1,  1'b0, 1'b0, 1'b1, 1'b0};
      vecs[2]  = '{2,  1'b0, 1'b1, 1'b0, 1'b0};
      vecs[3]  = '{3,  1'b0, 1'b1, 1'b1, 1'b1};
      vecs[4]  = '{4,  1'b0, 1'b1, 1'b0, 1'b1};
      vecs[5]  = '{5,  1'b0, 1'b0, 1'b1, 1'b1};
      vecs[6]  = '{6,  1'b0, 1'b0, 1'b0, 1'b1};
      vecs[7]  = '{7,  1'b0, 1'b1, 1'b1, 1'b0};
      vecs[8]  = '{29, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[9]  = '{30, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{31, 1'b1, 1'b0, 1'b1, 1'b1};
      vecs[11] = '{59, 1'b1, 1'b1, 1'b1, 1'b1};
      vecs[12] = '{60, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[13] = '{61, 1'b0, 1'b0, 1'b1, 1'b1};
      vecs[14] = '{90, 1'b1, 1'b0, 1'b0, 1'b1};

      // reset state, with no clock edge needed
      #3;
      check("rst_out60", {31'd0, out60}, 32'd0);
      check("rst_out7",  {31'd0, out7},  32'd0);
      repeat (3) @(posedge clk);
      #1;
      check("rst_hold_out5",   {31'd0, out5}, 32'd0);
      check("rst_hold_out2",   {31'd0, out2}, 32'd0);
      check("rst_hold_cnt60",  32'(dut60.count), 32'd0);
      check("rst_hold_cnt7",   32'(dut7.count),  32'd0);

      // table-driven vectors, edges counted from reset release
      @(negedge clk);
      reset    = 1'b1;
      edge_cnt = 0;
      #1;
      for (int i = 0; i < 15; i++) begin
         while (edge_cnt < vecs[i].edge_idx) step();
         check($sformatf("vec%0d_out60", i), {31'd0, out60}, {31'd0, vecs[i].exp60});
         check($sformatf("vec%0d_out5",  i), {31'd0, out5},  {31'd0, vecs[i].exp5});
         check($sformatf("vec%0d_out2",  i), {31'd0, out2},  {31'd0, vecs[i].exp2});
         check($sformatf("vec%0d_out7",  i), {31'd0, out7},  {31'd0, vecs[i].exp7});
         check($sformatf("vec%0d_cnt60", i), 32'(dut60.count), 32'(vecs[i].edge_idx % 60));
         check($sformatf("vec%0d_cnt7",  i), 32'(dut7.count),  32'(vecs[i].edge_idx % 7));
      end

      // 140 edges: N=7 rises every 7 cycles from edge 3, N=60 has two rises and two falls
      do_reset();
      for (int k = 0; k < 20; k++) exp_q.push_back(32'(3 + 7 * k));
      begin
         logic p7, p60;
         int   rises7, rises60, falls60;
         p7 = out7; p60 = out60;
         rises7 = 0; rises60 = 0; falls60 = 0;
         for (int e = 1; e <= 140; e++) begin
            step();
            check("n2_toggle", {31'd0, out2}, 32'(e % 2));
            check("n7_cnt_bound", {31'd0, (dut7.count <= 3'd6)}, 32'd1);
            if (out7 && !p7) begin
               rises7++;
               if (exp_q.size() == 0) check("n7_extra_rise", 32'(e), 32'd0);
               else check("n7_rise_edge", 32'(e), exp_q.pop_front());
            end
            if (out60 && !p60) rises60++;
            if (!out60 && p60) falls60++;
            p7 = out7; p60 = out60;
         end
         check("n7_rises",     32'(rises7),  32'd20);
         check("n7_q_left",    32'(exp_q.size()), 32'd0);
         check("n60_rises",    32'(rises60), 32'd2);
         check("n60_falls",    32'(falls60), 32'd2);
      end

      // asynchronous reset in the middle of the N=60 high phase
      do_reset();
      repeat (45) step();
      check("mid_high_out60", {31'd0, out60}, 32'd1);
      #2;
      reset = 1'b0;
      #1;
      check("async_rst_out60", {31'd0, out60}, 32'd0);
      check("async_rst_cnt60", 32'(dut60.count), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check("rst_held_out60", {31'd0, out60}, 32'd0);
      @(negedge clk);
      reset    = 1'b1;
      edge_cnt = 0;
      begin
         int low_bad;
         low_bad = 0;
         for (int e = 1; e <= 29; e++) begin
            step();
            if (out60 !== 1'b0) low_bad++;
         end
         check("restart_low_phase", 32'(low_bad), 32'd0);
         step();
         check("restart_rise_e30", {31'd0, out60}, 32'd1);
         check("restart_cnt_e30", 32'(dut60.count), 32'd30);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   // hard time limit so the run always ends
   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/divide_by_n.md
DIVIDE_BY_N -- requirements
Module: divide_by_n

Interface
REQ-001 SHALL have parameter N, default 60, meaning the output period in clk cycles; legal range N >= 2.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = in reset).
REQ-004 SHALL have port out, output, 1 bit: the divided clock-enable/square wave, driven directly from a flip-flop (glitch-free).

Function
REQ-005 SHALL contain a phase counter of width max(1, $clog2(N)) bits, counting 0..N-1.
REQ-006 SHALL increment the counter by 1 on every clk rising edge while reset is high.
REQ-007 SHALL wrap the counter from N-1 to 0 on the next edge, with no idle or skipped states; period is exactly N cycles.
REQ-008 SHALL register out such that out = 1 exactly when the current counter value >= floor(N/2), else 0.
REQ-008a SHALL achieve this by computing next-count first and registering out from next-count, so out and the counter update on the same edge with no added lag.
REQ-009 SHALL therefore hold out low for floor(N/2) cycles and high for ceil(N/2) cycles per period: 50% duty for even N, one extra high cycle for odd N.
REQ-010 SHALL produce exactly one 0->1 and one 1->0 transition of out per N-cycle period.
REQ-011 SHALL, for N = 2, toggle out on every clk edge.
REQ-012 SHALL reject N < 2 at elaboration with a fatal error/assertion; no runtime behaviour is defined for such N.
REQ-013 SHALL size all comparisons so that N values that are not powers of two never reach counter codes >= N.
REQ-014 SHALL not depend on any input other than clk and reset; there is no enable or load.

Reset
REQ-015 SHALL, when reset is low, asynchronously (without waiting for clk) force counter = 0 and out = 0.
REQ-016 SHALL hold counter = 0 and out = 0 for as long as reset remains low.
REQ-017 SHALL, on the first clk rising edge after reset goes high, move counter to 1, so out first rises on the edge where the counter reaches floor(N/2).
REQ-018 SHALL, if reset asserts mid-period, abandon the current phase and restart from counter 0 on release.

Structure
REQ-019 SHALL be a single flat module with no sub-modules and no shared package; the counter width is a local parameter derived from N.
REQ-020 SHALL use only two registers: the counter and out.
REQ-021 SHALL compute next-count combinationally and perform the async-reset register updates in one sequential block.

Verification
REQ-022 N=60: release reset -> out = 0 for the first 29 edges, rises on edge 30, stays high for 30 cycles, falls on edge 60; repeats with period 60.
REQ-023 N=5: after reset -> out pattern per cycle is 0,0,1,1,1 repeating (2 low, 3 high).
REQ-024 N=2: after reset -> out alternates 0,1,0,1 on consecutive edges.
REQ-025 N=60: assert reset (drive it to 0) mid-high-phase between clock edges -> out = 0 immediately; after release, the full 30-cycle low phase restarts.
REQ-026 Over 10 periods at N=7 -> exactly 10 rising edges of out, each 7 cycles apart; counter never exceeds 6.
REQ-027 Elaborate with N=1 -> build fails with a fatal parameter error.
